// File: rtl/constants_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : constants_pkg
//  Description : Shared defaults, serializer state encoding and pointer-width
//                helper for the constants_sink receive path.
//  Revision    : 1.0 - initial release
// ============================================================================
package constants_pkg;

    // Default geometry of the sink
    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_DEPTH  = 4;
    localparam int DEFAULT_DROP_W = 8;

    // FIFO pointers carry one extra wrap bit so full and empty are distinguishable
    localparam int DEFAULT_PTR_W  = $clog2(DEFAULT_DEPTH) + 1;

    // Serializer states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } sink_state_t;

    // Pointer width for an arbitrary power-of-two depth
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sink_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sink_fifo
//  Description : Synchronous FIFO with registered full/empty flags derived
//                from wrap-bit pointers. The head word is presented
//                combinationally from the storage array so the consumer can
//                load it in the same cycle it pops.
//  Revision    : 1.0 - initial release
// ============================================================================
module sink_fifo
    import constants_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W  = ptr_width(DEPTH);
    localparam int ADDR_W = PTR_W - 1;

    logic [WIDTH-1:0] r_mem [DEPTH];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic             r_full;
    logic             r_empty;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic             w_full_nxt;
    logic             w_empty_nxt;

    // Flags are the registered values, so a push while full is refused even
    // if a pop happens in the same cycle
    assign w_push_ok = push && !r_full;
    assign w_pop_ok  = pop  && !r_empty;

    assign w_wr_ptr_nxt = r_wr_ptr + PTR_W'(w_push_ok);
    assign w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_pop_ok);

    // Same slot with opposite wrap bits means every entry is occupied
    assign w_full_nxt  = (w_wr_ptr_nxt[PTR_W-1] != w_rd_ptr_nxt[PTR_W-1]) &&
                         (w_wr_ptr_nxt[ADDR_W-1:0] == w_rd_ptr_nxt[ADDR_W-1:0]);
    assign w_empty_nxt = (w_wr_ptr_nxt == w_rd_ptr_nxt);

    // Pointer and flag registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_full   <= w_full_nxt;
            r_empty  <= w_empty_nxt;
        end
    end

    // Storage array; contents need no reset because the pointers gate reads
    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= push_data;
        end
    end

    assign head_data = r_mem[r_rd_ptr[ADDR_W-1:0]];
    assign full      = r_full;
    assign empty     = r_empty;

endmodule
`default_nettype wire

// File: rtl/constants_sink.sv
`default_nettype none
// ============================================================================
//  Module      : constants_sink
//  Description : Captures result words on the reduce strobe, buffers them in
//                a small FIFO and shifts them out LSB-first on a framed
//                one-bit link with per-bit backpressure. Words arriving while
//                the FIFO is full are counted in a saturating drop counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module constants_sink
    import constants_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int DROP_W = DEFAULT_DROP_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [WIDTH-1:0]  in_word,
    input  logic              in_valid,
    input  logic              tx_ready,
    output logic              tx_bit,
    output logic              tx_frame,
    output logic              tx_last,
    output logic              full,
    output logic              empty,
    output logic [DROP_W-1:0] drop_count
);

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    sink_state_t       r_state;
    logic [WIDTH-1:0]  r_shreg;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_tx_frame;
    logic              r_tx_last;
    logic [DROP_W-1:0] r_drop;

    logic [WIDTH-1:0]  w_head;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_last_done;
    logic              w_fifo_pop;
    logic [CNT_W-1:0]  w_cnt_inc;

    sink_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (in_valid),
        .push_data (in_word),
        .pop       (w_fifo_pop),
        .head_data (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    // The final bit of a frame is consumed this cycle
    assign w_last_done = (r_state == ST_SHIFT) && tx_ready && (r_cnt == LAST_IDX);

    // Pop when idle with data waiting, or chain straight into the next frame
    assign w_fifo_pop  = !w_fifo_empty && ((r_state == ST_IDLE) || w_last_done);

    assign w_cnt_inc   = r_cnt + CNT_W'(1);

    // Serializer FSM: loads the head word, shifts one bit per accepted cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_shreg    <= '0;
            r_cnt      <= '0;
            r_tx_frame <= 1'b0;
            r_tx_last  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_fifo_pop) begin
                        r_state    <= ST_SHIFT;
                        r_shreg    <= w_head;
                        r_cnt      <= '0;
                        r_tx_frame <= 1'b1;
                        r_tx_last  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (tx_ready) begin
                        if (r_cnt == LAST_IDX) begin
                            if (w_fifo_pop) begin
                                // Back-to-back frame: frame flag stays high
                                r_shreg    <= w_head;
                                r_cnt      <= '0;
                                r_tx_last  <= 1'b0;
                            end else begin
                                r_state    <= ST_IDLE;
                                r_shreg    <= '0;
                                r_cnt      <= '0;
                                r_tx_frame <= 1'b0;
                                r_tx_last  <= 1'b0;
                            end
                        end else begin
                            r_shreg   <= r_shreg >> 1;
                            r_cnt     <= w_cnt_inc;
                            r_tx_last <= (w_cnt_inc == LAST_IDX);
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_tx_frame <= 1'b0;
                    r_tx_last  <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of words refused because the FIFO was full
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_drop <= '0;
        end else if (in_valid && w_fifo_full && (r_drop != {DROP_W{1'b1}})) begin
            r_drop <= r_drop + DROP_W'(1);
        end
    end

    // The shift register LSB is itself a flop, so the serial bit is registered
    // and holds naturally while the receiver stalls
    assign tx_bit     = r_shreg[0];
    assign tx_frame   = r_tx_frame;
    assign tx_last    = r_tx_last;
    assign full       = w_fifo_full;
    assign empty      = w_fifo_empty;
    assign drop_count = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_constants_sink.sv
`default_nettype none
// ============================================================================
//  Module      : tb_constants_sink
//  Description : Self-checking bench for constants_sink. A queue-based
//                transaction model predicts every output each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_constants_sink;

    localparam int WIDTH  = 16;
    localparam int DEPTH  = 4;
    localparam int DROP_W = 8;

    logic              clock = 1'b0;
    logic              reset_n = 1'b1;
    logic [WIDTH-1:0]  in_word = '0;
    logic              in_valid = 1'b0;
    logic              tx_ready = 1'b0;
    logic              tx_bit;
    logic              tx_frame;
    logic              tx_last;
    logic              full;
    logic              empty;
    logic [DROP_W-1:0] drop_count;

    int checks = 0;
    int errors = 0;

    // Reference model state: queued words plus the word currently on the link
    logic [WIDTH-1:0]  m_q[$];
    logic [WIDTH-1:0]  m_cur;
    int                m_pos;
    bit                m_busy;
    logic [DROP_W-1:0] m_drop;

    constants_sink #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .DROP_W (DROP_W)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_word    (in_word),
        .in_valid   (in_valid),
        .tx_ready   (tx_ready),
        .tx_bit     (tx_bit),
        .tx_frame   (tx_frame),
        .tx_last    (tx_last),
        .full       (full),
        .empty      (empty),
        .drop_count (drop_count)
    );

    always #5 clock = ~clock;

    localparam logic [12:0] RESET_VEC = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};

    function automatic logic [12:0] dut_vec();
        return {tx_frame, tx_bit, tx_last, full, empty, drop_count};
    endfunction

    function automatic logic [12:0] exp_vec();
        logic b;
        logic l;
        b = m_busy ? m_cur[m_pos] : 1'b0;
        l = m_busy && (m_pos == WIDTH - 1);
        return {m_busy, b, l, (m_q.size() == DEPTH), (m_q.size() == 0), m_drop};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_cur  = '0;
        m_pos  = 0;
        m_busy = 0;
        m_drop = '0;
    endtask

    // One clock edge of the link: a word starts when the buffer has one and the
    // link is free or just finished; a push is refused when the buffer was full
    task automatic model_step(input logic v, input logic [WIDTH-1:0] w, input logic r);
        int s;
        s = m_q.size();
        if (!m_busy) begin
            if (s > 0) begin
                m_cur  = m_q.pop_front();
                m_pos  = 0;
                m_busy = 1;
            end
        end else if (r) begin
            if (m_pos == WIDTH - 1) begin
                if (s > 0) begin
                    m_cur = m_q.pop_front();
                    m_pos = 0;
                end else begin
                    m_busy = 0;
                end
            end else begin
                m_pos++;
            end
        end
        if (v) begin
            if (s < DEPTH) m_q.push_back(w);
            else if (m_drop != 8'hFF) m_drop++;
        end
    endtask

    task automatic tick(input logic v, input logic [WIDTH-1:0] w, input logic r);
        in_valid = v;
        in_word  = w;
        tx_ready = r;
        @(posedge clock);
        model_step(v, w, r);
        #1;
    endtask

    task automatic quick_reset();
        in_valid = 1'b0;
        tx_ready = 1'b0;
        reset_n  = 1'b0;
        #2;
        model_reset();
        checks++;
        if (dut_vec() !== RESET_VEC) begin
            errors++;
            $display("FAIL quick_reset: got %b expected %b", dut_vec(), RESET_VEC);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({tx_frame, tx_bit, tx_last} !== 3'b000) begin
            errors++;
            $display("FAIL reset_tx: got %b expected 000", {tx_frame, tx_bit, tx_last});
        end
        checks++;
        if ({full, empty} !== 2'b01) begin
            errors++;
            $display("FAIL reset_flags: got full/empty %b expected 01", {full, empty});
        end
        checks++;
        if (drop_count !== 8'h00) begin
            errors++;
            $display("FAIL reset_drop: got %h expected 00", drop_count);
        end
        #2 reset_n = 1'b1;
    endtask

    task automatic test_single_frame();
        logic [WIDTH-1:0] rx;
        logic [WIDTH-1:0] lastmask;
        quick_reset();
        tick(1'b1, 16'hA5C3, 1'b1);
        checks++;
        if (tx_frame !== 1'b0 || empty !== 1'b0) begin
            errors++;
            $display("FAIL single_latency1: got frame=%b empty=%b expected frame=0 empty=0", tx_frame, empty);
        end
        tick(1'b0, '0, 1'b1);
        checks++;
        if (tx_frame !== 1'b1) begin
            errors++;
            $display("FAIL single_latency2: got frame=%b expected 1", tx_frame);
        end
        for (int i = 0; i < WIDTH; i++) begin
            rx[i]       = tx_bit;
            lastmask[i] = tx_last;
            tick(1'b0, '0, 1'b1);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL single_cycle %0d: got %b expected %b", i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (rx !== 16'hA5C3) begin
            errors++;
            $display("FAIL single_bits: got %h expected a5c3", rx);
        end
        checks++;
        if (lastmask !== 16'h8000) begin
            errors++;
            $display("FAIL single_last: got %h expected 8000", lastmask);
        end
        checks++;
        if (tx_frame !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL single_end: got frame=%b empty=%b expected frame=0 empty=1", tx_frame, empty);
        end
    endtask

    task automatic test_back_to_back();
        logic [2*WIDTH-1:0] rx;
        int gaps;
        quick_reset();
        gaps = 0;
        tick(1'b1, 16'h0001, 1'b1);
        tick(1'b1, 16'h8000, 1'b1);
        for (int i = 0; i < 2 * WIDTH; i++) begin
            if (tx_frame !== 1'b1) gaps++;
            rx[i] = tx_bit;
            tick(1'b0, '0, 1'b1);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL b2b_cycle %0d: got %b expected %b", i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (gaps != 0) begin
            errors++;
            $display("FAIL b2b_gaps: got %0d unframed cycles expected 0", gaps);
        end
        checks++;
        if (rx !== 32'h8000_0001) begin
            errors++;
            $display("FAIL b2b_bits: got %h expected 80000001", rx);
        end
        checks++;
        if (tx_frame !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: got frame=%b expected 0", tx_frame);
        end
    endtask

    task automatic test_backpressure();
        int cnt;
        int guard;
        quick_reset();
        cnt = 0;
        guard = 0;
        tick(1'b1, 16'h0008, 1'b1);
        tick(1'b0, '0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cnt++;
            tick(1'b0, '0, 1'b1);
        end
        for (int k = 0; k < 5; k++) begin
            cnt++;
            checks++;
            if (tx_bit !== 1'b1) begin
                errors++;
                $display("FAIL hold_bit %0d: got %b expected 1", k, tx_bit);
            end
            tick(1'b0, '0, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL hold_cycle %0d: got %b expected %b", k, dut_vec(), exp_vec());
            end
        end
        while (tx_frame === 1'b1 && guard < 40) begin
            cnt++;
            guard++;
            tick(1'b0, '0, 1'b1);
        end
        checks++;
        if (cnt != 21) begin
            errors++;
            $display("FAIL hold_length: got %0d cycles expected 21", cnt);
        end
    endtask

    task automatic test_overflow();
        quick_reset();
        for (int k = 1; k <= 8; k++) begin
            tick(1'b1, 16'($urandom()), 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL overflow_cycle %0d: got %b expected %b", k, dut_vec(), exp_vec());
            end
            if (k == 4 || k == 5) begin
                checks++;
                if (full !== (k == 5)) begin
                    errors++;
                    $display("FAIL overflow_full after %0d: got %b expected %b", k, full, (k == 5));
                end
            end
        end
        checks++;
        if (drop_count !== 8'd3) begin
            errors++;
            $display("FAIL overflow_drop: got %0d expected 3", drop_count);
        end
    endtask

    task automatic test_saturation();
        quick_reset();
        for (int k = 0; k < 305; k++) begin
            tick(1'b1, 16'($urandom()), 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL sat_cycle %0d: got %b expected %b", k, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (drop_count !== 8'd255) begin
            errors++;
            $display("FAIL sat_drop: got %0d expected 255", drop_count);
        end
    endtask

    task automatic test_reset_mid_frame();
        quick_reset();
        tick(1'b1, 16'($urandom()), 1'b1);
        tick(1'b1, 16'($urandom()), 1'b1);
        tick(1'b1, 16'($urandom()), 1'b1);
        for (int k = 0; k < 6; k++) begin
            tick(1'b0, '0, 1'b1);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL midrst_pre %0d: got %b expected %b", k, dut_vec(), exp_vec());
            end
        end
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (dut_vec() !== RESET_VEC) begin
            errors++;
            $display("FAIL midrst_async: got %b expected %b", dut_vec(), RESET_VEC);
        end
        #2 reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick(1'b0, '0, 1'b1);
            checks++;
            if (tx_frame !== 1'b0 || dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL midrst_post %0d: got %b expected %b", k, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic v;
        logic r;
        quick_reset();
        for (int k = 0; k < 800; k++) begin
            v = (k < 400) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
            r = ($urandom_range(0, 3) != 0);
            tick(v, 16'($urandom()), r);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_cycle %0d: got %b expected %b", k, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_saturation();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
